// File: rtl/z16_pkg.sv
// Shared Z16 decode definitions: opcode constants, immediate formats and the
// decoded-instruction record produced from a raw 16-bit instruction word.
package z16_pkg;

  localparam logic [3:0] OP_ALU_MAX = 4'h8;
  localparam logic [3:0] OP_ADDI    = 4'h9;
  localparam logic [3:0] OP_LOAD    = 4'hA;
  localparam logic [3:0] OP_STORE   = 4'hB;

  typedef enum logic [1:0] {
    NONE,
    I8,
    L4,
    S4
  } imm_fmt_e;

  // imm8 is already sign-extended to 8 bits; the stage widens it to DATA_W.
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] imm8;
    logic       rd_we;
    logic       mem_we;
    logic [3:0] alu_ctrl;
    logic       use_rs1;
    logic       use_rs2;
  } dec_instr_t;

  function automatic imm_fmt_e imm_fmt(input logic [3:0] op);
    case (op)
      OP_ADDI:  return I8;
      OP_LOAD:  return L4;
      OP_STORE: return S4;
      default:  return NONE;
    endcase
  endfunction

  function automatic dec_instr_t decode(input logic [15:0] instr);
    dec_instr_t d;
    logic [3:0] op;
    op         = instr[3:0];
    d          = '0;
    d.opcode   = op;
    d.rd       = instr[7:4];
    d.rs2      = instr[15:12];
    d.rs1      = (op == OP_ADDI) ? instr[7:4] : instr[11:8];
    case (imm_fmt(op))
      I8:      d.imm8 = instr[15:8];
      L4:      d.imm8 = {{4{instr[15]}}, instr[15:12]};
      S4:      d.imm8 = {{4{instr[7]}}, instr[7:4]};
      default: d.imm8 = '0;
    endcase
    d.rd_we    = (op <= OP_LOAD);
    d.mem_we   = (op == OP_STORE);
    d.alu_ctrl = (op <= OP_ALU_MAX) ? op : 4'h0;
    d.use_rs1  = (op <= OP_STORE);
    d.use_rs2  = (op <= OP_ALU_MAX) || (op == OP_STORE);
    return d;
  endfunction

endpackage

// File: rtl/z16_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// writeback, plus the hazard lookup for an incoming instruction.
module z16_scoreboard
  import z16_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_set_en,
  input  logic [3:0] i_set_addr,
  input  logic       i_clr_en,
  input  logic [3:0] i_clr_addr,
  input  logic       i_inflight_en,
  input  logic [3:0] i_inflight_addr,
  input  logic [3:0] i_rs1_addr,
  input  logic       i_rs1_use,
  input  logic [3:0] i_rs2_addr,
  input  logic       i_rs2_use,
  input  logic [3:0] i_rd_addr,
  input  logic       i_rd_use,
  output logic       o_busy
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Clear first, then set, so an issue and a retire to the same register
  // leave the bit set (the new writer is still outstanding).
  always_comb begin
    pending_d = pending_q;
    if (i_clr_en) pending_d[i_clr_addr] = 1'b0;
    if (i_set_en) pending_d[i_set_addr] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  function automatic logic reg_busy(input logic [3:0] a);
    return pending_q[a] || (i_inflight_en && (a == i_inflight_addr));
  endfunction

  assign o_busy = (i_rs1_use && reg_busy(i_rs1_addr)) ||
                  (i_rs2_use && reg_busy(i_rs2_addr)) ||
                  (i_rd_use  && reg_busy(i_rd_addr));

endmodule

// File: rtl/z16_decode_stage.sv
// Z16 decode pipeline stage with valid/ready handshakes. Define
// Z16_SCOREBOARD_EN to add the pending-write scoreboard, hazard stalls and stall counter.
module z16_decode_stage
  import z16_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [15:0]       i_instr,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [3:0]        o_opcode,
  output logic [3:0]        o_rd_addr,
  output logic [3:0]        o_rs1_addr,
  output logic [3:0]        o_rs2_addr,
  output logic [DATA_W-1:0] o_imm,
  output logic              o_rd_we,
  output logic              o_mem_we,
  output logic [3:0]        o_alu_ctrl,
  input  logic              i_flush,
  input  logic              i_wb_we,
  input  logic [3:0]        i_wb_addr,
  output logic [15:0]       o_stall_cnt
);

  dec_instr_t        dec;
  logic              hazard;
  logic              accept;
  logic              valid_q, valid_d;
  logic [3:0]        opcode_q, rd_q, rs1_q, rs2_q, alu_ctrl_q;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              rd_we_q, mem_we_q;

  assign dec     = decode(i_instr);
  assign imm_d   = {{(DATA_W-8){dec.imm8[7]}}, dec.imm8};
  assign o_ready = !i_flush && (!valid_q || i_ready) && !hazard;
  assign accept  = i_valid && o_ready;

  // A flush or a consumed hold empties the stage unless a new word arrives.
  always_comb begin
    valid_d = valid_q;
    if (accept)                valid_d = 1'b1;
    else if (i_flush || i_ready) valid_d = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q    <= 1'b0;
      opcode_q   <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      rd_we_q    <= 1'b0;
      mem_we_q   <= 1'b0;
      alu_ctrl_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        opcode_q   <= dec.opcode;
        rd_q       <= dec.rd;
        rs1_q      <= dec.rs1;
        rs2_q      <= dec.rs2;
        imm_q      <= imm_d;
        rd_we_q    <= dec.rd_we;
        mem_we_q   <= dec.mem_we;
        alu_ctrl_q <= dec.alu_ctrl;
      end
    end
  end

`ifdef Z16_SCOREBOARD_EN
  logic        busy;
  logic        issue;
  logic [15:0] stall_q, stall_d;

  assign issue  = valid_q && i_ready && rd_we_q;
  assign hazard = i_valid && busy;

  z16_scoreboard #(.NREG(NREG)) u_scoreboard (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_set_en        (issue),
    .i_set_addr      (rd_q),
    .i_clr_en        (i_wb_we),
    .i_clr_addr      (i_wb_addr),
    .i_inflight_en   (valid_q && rd_we_q),
    .i_inflight_addr (rd_q),
    .i_rs1_addr      (dec.rs1),
    .i_rs1_use       (dec.use_rs1),
    .i_rs2_addr      (dec.rs2),
    .i_rs2_use       (dec.use_rs2),
    .i_rd_addr       (dec.rd),
    .i_rd_use        (dec.rd_we),
    .o_busy          (busy)
  );

  always_comb begin
    stall_d = stall_q;
    if (hazard && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign o_stall_cnt = stall_q;
`else
  logic            unused_sb;
  logic [NREG-1:0] unused_regs;

  assign hazard      = 1'b0;
  assign o_stall_cnt = '0;
  assign unused_sb   = ^{i_wb_we, i_wb_addr, dec.use_rs1, dec.use_rs2};
  assign unused_regs = '0;
`endif

  assign o_valid    = valid_q;
  assign o_opcode   = opcode_q;
  assign o_rd_addr  = rd_q;
  assign o_rs1_addr = rs1_q;
  assign o_rs2_addr = rs2_q;
  assign o_imm      = imm_q;
  assign o_rd_we    = rd_we_q;
  assign o_mem_we   = mem_we_q;
  assign o_alu_ctrl = alu_ctrl_q;

endmodule

// File: tb/tb_z16_decode_stage.sv
// Self-checking bench for z16_decode_stage: directed cases plus randomized
// traffic against a behavioural model of the decode and hazard rules.
module tb_z16_decode_stage;

  localparam int DATA_W = 16;
`ifdef Z16_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic [15:0]       i_instr = '0;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic              o_valid;
  logic              i_ready = 1'b0;
  logic [3:0]        o_opcode, o_rd_addr, o_rs1_addr, o_rs2_addr, o_alu_ctrl;
  logic [DATA_W-1:0] o_imm;
  logic              o_rd_we, o_mem_we;
  logic              i_flush = 1'b0;
  logic              i_wb_we = 1'b0;
  logic [3:0]        i_wb_addr = '0;
  logic [15:0]       o_stall_cnt;

  z16_decode_stage #(.DATA_W(DATA_W), .NREG(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_instr(i_instr), .i_valid(i_valid),
    .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready),
    .o_opcode(o_opcode), .o_rd_addr(o_rd_addr), .o_rs1_addr(o_rs1_addr),
    .o_rs2_addr(o_rs2_addr), .o_imm(o_imm), .o_rd_we(o_rd_we),
    .o_mem_we(o_mem_we), .o_alu_ctrl(o_alu_ctrl), .i_flush(i_flush),
    .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .o_stall_cnt(o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state: the held word, outstanding writers, stall count.
  bit          m_valid;
  logic [15:0] m_instr;
  bit          pend [16];
  int          m_stall;

  function automatic int op_of(input logic [15:0] w);  return int'(w[3:0]);  endfunction
  function automatic int rd_of(input logic [15:0] w);  return int'(w[7:4]);  endfunction
  function automatic int rs2_of(input logic [15:0] w); return int'(w[15:12]); endfunction
  function automatic int rs1_of(input logic [15:0] w);
    return (op_of(w) == 9) ? int'(w[7:4]) : int'(w[11:8]);
  endfunction
  function automatic bit rdwe_of(input logic [15:0] w); return op_of(w) <= 10; endfunction
  function automatic bit use1_of(input logic [15:0] w); return op_of(w) <= 11; endfunction
  function automatic bit use2_of(input logic [15:0] w);
    return (op_of(w) <= 8) || (op_of(w) == 11);
  endfunction
  function automatic int imm_of(input logic [15:0] w);
    int v;
    case (op_of(w))
      9:       begin v = int'(w[15:8]);  if (v > 127) v -= 256; end
      10:      begin v = int'(w[15:12]); if (v > 7)   v -= 16;  end
      11:      begin v = int'(w[7:4]);   if (v > 7)   v -= 16;  end
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic bit busy(input int r);
    return pend[r] || (m_valid && rdwe_of(m_instr) && (r == rd_of(m_instr)));
  endfunction

  function automatic bit hazard_of(input logic [15:0] w, input bit v);
    return SB_EN && v && ((use1_of(w) && busy(rs1_of(w))) ||
                          (use2_of(w) && busy(rs2_of(w))) ||
                          (rdwe_of(w) && busy(rd_of(w))));
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_instr = '0;
    m_stall = 0;
    for (int r = 0; r < 16; r++) pend[r] = 1'b0;
  endtask

  task automatic check_fields(input string tag, input logic [15:0] w);
    logic [DATA_W-1:0] e_imm;
    e_imm = DATA_W'(imm_of(w));
    check({tag, "_op"},   o_opcode,   op_of(w));
    check({tag, "_rd"},   o_rd_addr,  rd_of(w));
    check({tag, "_rs1"},  o_rs1_addr, rs1_of(w));
    check({tag, "_rs2"},  o_rs2_addr, rs2_of(w));
    check({tag, "_imm"},  o_imm,      e_imm);
    check({tag, "_rdwe"}, o_rd_we,    rdwe_of(w));
    check({tag, "_mwe"},  o_mem_we,   op_of(w) == 11);
    check({tag, "_alu"},  o_alu_ctrl, (op_of(w) <= 8) ? op_of(w) : 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_stall"}, o_stall_cnt, 0);
    check({tag, "_dec"}, {o_opcode, o_rd_addr, o_rs1_addr, o_rs2_addr, o_alu_ctrl,
                          o_rd_we, o_mem_we}, 0);
    check({tag, "_imm"}, o_imm, 0);
  endtask

  // One clock: drive at posedge+1, compare at negedge, advance model at posedge.
  task automatic cycle(input logic [15:0] w, input bit v, input bit rdy,
                       input bit fl = 1'b0, input bit wbwe = 1'b0,
                       input logic [3:0] wba = 4'h0);
    bit e_haz, e_rdy;
    i_instr = w; i_valid = v; i_ready = rdy; i_flush = fl;
    i_wb_we = wbwe; i_wb_addr = wba;
    @(negedge i_clk);
    e_haz = hazard_of(w, v);
    e_rdy = !fl && (!m_valid || rdy) && !e_haz;
    check("ready", o_ready, e_rdy);
    check("valid", o_valid, m_valid);
    check("stall_cnt", o_stall_cnt, m_stall);
    if (m_valid) check_fields("held", m_instr);
    @(posedge i_clk);
    if (SB_EN) begin
      if (wbwe) pend[wba] = 1'b0;
      if (m_valid && rdy && rdwe_of(m_instr)) pend[rd_of(m_instr)] = 1'b1;
      if (e_haz && m_stall < 65535) m_stall++;
    end
    if (v && e_rdy) begin
      m_valid = 1'b1;
      m_instr = w;
    end else if (fl || (m_valid && rdy)) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  // Reset asserted between edges; outputs must clear before any clock.
  task automatic apply_reset(input string tag);
    #2;
    i_rst = 1'b1;
    #1;
    check_reset_state(tag);
    check({tag, "_ready"}, o_ready, !i_flush);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    #1;
    apply_reset("por");

    // Immediate formats and control decode.
    cycle(16'hFF29, 1, 1);
    check("addi_imm_ones", o_imm, {DATA_W{1'b1}});
    check_fields("addi", 16'hFF29);
    cycle(16'h731A, 1, 1, 0, 1, 4'h2);
    check("load_imm7", o_imm, 7);
    check_fields("load", 16'h731A);
    cycle(16'h42FB, 1, 1);
    cycle(16'h0000, 0, 1, 0, 1, 4'h2);
    cycle(16'h42FB, 1, 1);
    check("store_mwe", o_mem_we, 1);
    check_fields("store", 16'h42FB);
    cycle(16'h0000, 0, 1);

    // Back-pressure: held word stays put for three cycles.
    apply_reset("rst_bp");
    cycle(16'hABCC, 1, 1);
    for (int k = 0; k < 3; k++) cycle(16'h567D, 1, 0);
    check("bp_held", o_opcode, 4'hC);
    cycle(16'h567D, 1, 1);
    check("bp_next", o_opcode, 4'hD);
    cycle(16'h0000, 0, 1);

    // Flush drops the incoming word; the issuing one still marks its rd.
    apply_reset("rst_fl");
    cycle(16'h3210, 1, 1);
    cycle(16'h0C0C, 1, 1, 1);
    check("flush_valid", o_valid, 0);
    cycle(16'h5140, 1, 1);
    cycle(16'h5140, 1, 1, 0, 1, 4'h1);
    cycle(16'h5140, 1, 1);
    cycle(16'h0000, 0, 1);

    // RAW stall until the writer retires.
    apply_reset("rst_hz");
    cycle(16'h3210, 1, 1);
    for (int k = 0; k < 4; k++) cycle(16'h5140, 1, 1);
`ifdef Z16_SCOREBOARD_EN
    check("stall_four", o_stall_cnt, 4);
`endif
    cycle(16'h5140, 1, 1, 0, 1, 4'h1);
    cycle(16'h5140, 1, 1);
    cycle(16'h0000, 0, 1);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      cycle(16'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)));
    end

    // Async reset in the middle of a stall.
    apply_reset("rst_pre");
    cycle(16'h3210, 1, 1);
    cycle(16'h5140, 1, 1);
    cycle(16'h5140, 1, 1);
    i_instr = 16'h5140; i_valid = 1'b1; i_ready = 1'b1; i_flush = 1'b0; i_wb_we = 1'b0;
    apply_reset("rst_mid");
    cycle(16'h5140, 1, 1);
    cycle(16'h0000, 0, 1);
    check_fields("post_rst", 16'h5140);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
